// File: rtl/music_pkg.sv
// Shared constants, song ROM and pitch table for the music player.
package music_pkg;

   localparam int unsigned NUM_SONGS      = 4;
   localparam int unsigned NOTES_PER_SONG = 32;
   localparam int unsigned SONG_W         = 2;
   localparam int unsigned INDEX_W        = 5;
   localparam int unsigned NOTE_W         = 6;
   localparam int unsigned DUR_W          = 6;
   localparam int unsigned ENTRY_W        = NOTE_W + DUR_W;
   localparam int unsigned ADDR_W         = SONG_W + INDEX_W;
   localparam int unsigned PHASE_W        = 20;
   localparam int unsigned SAMPLE_W       = 16;

   localparam logic signed [SAMPLE_W-1:0] AMPLITUDE     = 16'sh1000;
   localparam logic signed [SAMPLE_W-1:0] NEG_AMPLITUDE = -16'sh1000;

   typedef enum logic {
      PAUSED  = 1'b0,
      PLAYING = 1'b1
   } play_state_t;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [DUR_W-1:0]  duration;
   } song_entry_t;

   // Unlisted addresses read as all-zero, i.e. an end marker.
   function automatic song_entry_t song_rom(input logic [SONG_W-1:0]  song,
                                            input logic [INDEX_W-1:0] index);
      logic [ADDR_W-1:0]  addr;
      logic [ENTRY_W-1:0] raw;
      addr = {song, index};
      case (addr)
         7'd0:    raw = {6'd32, 6'd2};
         7'd1:    raw = {6'd16, 6'd1};
         7'd2:    raw = {6'd0,  6'd1};
         7'd32:   raw = {6'd8,  6'd3};
         7'd33:   raw = {6'd48, 6'd1};
         7'd64:   raw = {6'd4,  6'd2};
         7'd65:   raw = {6'd12, 6'd4};
         7'd66:   raw = {6'd24, 6'd2};
         7'd96:   raw = {6'd2,  6'd1};
         7'd97:   raw = {6'd1,  6'd1};
         7'd98:   raw = {6'd40, 6'd3};
         default: raw = '0;
      endcase
      return raw;
   endfunction

   // Linear pitch table: 64 entries, step grows by 4096 per note number.
   function automatic logic [PHASE_W-1:0] phase_step(input logic [NOTE_W-1:0] note);
      return {2'b00, note, 12'h000};
   endfunction

endpackage

// File: rtl/music_player_note_player.sv
// Square-wave tone generator: phase accumulator and registered PCM sample.
module note_player
   import music_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                note_load,
   input  logic                new_frame,
   input  logic                enable,
   input  logic [PHASE_W-1:0]  step,
   output logic [SAMPLE_W-1:0] sample
);

   logic [PHASE_W-1:0] phase;

   // A note load restarts the waveform even if a frame arrives the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
      end else if (note_load) begin
         phase <= '0;
      end else if (new_frame && enable) begin
         phase <= phase + step;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample <= '0;
      end else if (new_frame) begin
         if (!enable) begin
            sample <= '0;
         end else if (phase[PHASE_W-1]) begin
            sample <= NEG_AMPLITUDE;
         end else begin
            sample <= AMPLITUDE;
         end
      end
   end

endmodule

// File: rtl/music_player.sv
// Song sequencer: play/pause FSM, beat timing and note stepping through the song ROM.
module music_player
   import music_pkg::*;
#(
   parameter int unsigned BEAT_COUNT = 500
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        play_button,
   input  logic        next_button,
   input  logic        new_frame,
   output logic [15:0] sample_out
);

   localparam int unsigned       BEAT_W    = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_COUNT - 1);

   play_state_t          state, state_n;
   logic [SONG_W-1:0]    song, song_n;
   logic [INDEX_W-1:0]   index, index_n;
   logic [DUR_W-1:0]     remaining, remaining_n;
   logic [BEAT_W-1:0]    beat_cnt, beat_cnt_n;
   logic                 loaded;
   logic                 play_q, next_q;
   logic                 play_edge_c, next_edge_c, beat_c, note_load_c;
   song_entry_t          entry, load_entry;

   assign entry       = song_rom(song, index);
   assign play_edge_c = play_button & ~play_q;
   assign next_edge_c = next_button & ~next_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= PAUSED;
         song      <= '0;
         index     <= '0;
         remaining <= '0;
         beat_cnt  <= '0;
         loaded    <= 1'b0;
         play_q    <= 1'b0;
         next_q    <= 1'b0;
      end else begin
         state     <= state_n;
         song      <= song_n;
         index     <= index_n;
         remaining <= remaining_n;
         beat_cnt  <= beat_cnt_n;
         loaded    <= 1'b1;
         play_q    <= play_button;
         next_q    <= next_button;
      end
   end

   // Next-song has priority over everything; the first cycle after reset only loads.
   always_comb begin
      state_n     = state;
      song_n      = song;
      index_n     = index;
      remaining_n = remaining;
      beat_cnt_n  = beat_cnt;
      note_load_c = 1'b0;
      load_entry  = '0;
      beat_c      = (state == PLAYING) && (beat_cnt == BEAT_LAST);

      if (next_edge_c) begin
         song_n      = song + 1'b1;
         index_n     = '0;
         state_n     = PAUSED;
         beat_cnt_n  = '0;
         note_load_c = 1'b1;
      end else if (!loaded) begin
         note_load_c = 1'b1;
      end else begin
         if (play_edge_c) begin
            state_n = (state == PLAYING) ? PAUSED : PLAYING;
         end
         if (state == PLAYING) begin
            if (entry.duration == '0) begin
               state_n     = PAUSED;
               index_n     = '0;
               beat_cnt_n  = '0;
               note_load_c = 1'b1;
            end else begin
               beat_cnt_n = beat_c ? '0 : beat_cnt + 1'b1;
               if (beat_c) begin
                  if (remaining <= DUR_W'(1)) begin
                     index_n     = index + 1'b1;
                     note_load_c = 1'b1;
                  end else begin
                     remaining_n = remaining - 1'b1;
                  end
               end
            end
         end
      end

      load_entry = song_rom(song_n, index_n);
      if (note_load_c) begin
         remaining_n = load_entry.duration;
      end
   end

   note_player u_note (
      .clk       (clk),
      .reset     (reset),
      .note_load (note_load_c),
      .new_frame (new_frame),
      .enable    ((state == PLAYING) && (entry.note != '0)),
      .step      (phase_step(entry.note)),
      .sample    (sample_out)
   );

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with BEAT_COUNT=10 and a frame strobe every cycle.
module tb_music_player;

   logic        clk;
   logic        reset;
   logic        play_button;
   logic        next_button;
   logic        new_frame;
   logic [15:0] sample_out;

   int n_checks = 0;
   int n_pass   = 0;

   music_player #(.BEAT_COUNT(10)) dut (
      .clk         (clk),
      .reset       (reset),
      .play_button (play_button),
      .next_button (next_button),
      .new_frame   (new_frame),
      .sample_out  (sample_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic play, input logic next);
      play_button = play;
      next_button = next;
      tick();
      play_button = 1'b0;
      next_button = 1'b0;
   endtask

   localparam logic [31:0] POS = 32'h0000_1000;
   localparam logic [31:0] NEG = 32'h0000_F000;

   initial begin
      reset       = 1'b0;
      play_button = 1'b0;
      next_button = 1'b0;
      new_frame   = 1'b1;
      repeat (3) tick();
      check("rst_sample", 32'(sample_out), 32'h0);
      check("rst_state",  32'(dut.state), 32'd0);
      check("rst_song",   32'(dut.song), 32'd0);
      check("rst_index",  32'(dut.index), 32'd0);

      reset = 1'b1;
      repeat (26) tick();
      check("idle_sample", 32'(sample_out), 32'h0);
      check("idle_state",  32'(dut.state), 32'd0);
      check("idle_song",   32'(dut.song), 32'd0);
      check("idle_remain", 32'(dut.remaining), 32'd2);

      // Song 0 entry 0: note 32, step 0x20000 -> four frames high, four low.
      pulse(1'b1, 1'b0);
      check("play_state", 32'(dut.state), 32'd1);
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k <= 20)
            check($sformatf("tone0_k%0d", k), 32'(sample_out), (((k - 1) >> 2) & 1) != 0 ? NEG : POS);
         else
            check("tone1_start", 32'(sample_out), POS);
         if (k == 19) check("idx_before", 32'(dut.index), 32'd0);
         if (k == 20) begin
            check("idx_adv", 32'(dut.index), 32'd1);
            check("remain_adv", 32'(dut.remaining), 32'd1);
         end
      end

      // Pause mid-note and hold.
      pulse(1'b1, 1'b0);
      check("pause_state", 32'(dut.state), 32'd0);
      tick();
      check("pause_sample", 32'(sample_out), 32'h0);
      repeat (50) tick();
      check("frz_index",  32'(dut.index), 32'd1);
      check("frz_remain", 32'(dut.remaining), 32'd1);
      check("frz_beat",   32'(dut.beat_cnt), 32'd2);
      check("frz_phase",  32'(dut.u_note.phase), 32'h20000);
      check("frz_sample", 32'(sample_out), 32'h0);

      // Resume: phase continues from 0x20000, beat counter from 2.
      pulse(1'b1, 1'b0);
      tick();
      check("res_sample1", 32'(sample_out), POS);
      repeat (6) tick();
      check("res_sample7", 32'(sample_out), NEG);
      check("res_idx7",    32'(dut.index), 32'd1);
      tick();
      check("res_idx8",    32'(dut.index), 32'd2);
      tick();
      check("rest_sample", 32'(sample_out), 32'h0);
      repeat (9) tick();
      check("end_idx",     32'(dut.index), 32'd3);
      tick();
      check("end_state",   32'(dut.state), 32'd0);
      check("end_index",   32'(dut.index), 32'd0);
      check("end_song",    32'(dut.song), 32'd0);
      check("end_remain",  32'(dut.remaining), 32'd2);

      // Next while playing.
      pulse(1'b1, 1'b0);
      repeat (3) tick();
      pulse(1'b0, 1'b1);
      check("next_song",   32'(dut.song), 32'd1);
      check("next_state",  32'(dut.state), 32'd0);
      check("next_index",  32'(dut.index), 32'd0);
      check("next_remain", 32'(dut.remaining), 32'd3);
      tick();
      check("next_sample", 32'(sample_out), 32'h0);
      pulse(1'b1, 1'b0);
      check("s1_state", 32'(dut.state), 32'd1);
      tick();
      check("s1_sample", 32'(sample_out), POS);

      // Play and next together: next wins, play ignored.
      pulse(1'b1, 1'b1);
      check("both1_song",  32'(dut.song), 32'd2);
      check("both1_state", 32'(dut.state), 32'd0);
      tick();
      pulse(1'b1, 1'b1);
      check("both2_song",  32'(dut.song), 32'd3);
      check("both2_state", 32'(dut.state), 32'd0);
      tick();
      pulse(1'b0, 1'b1);
      check("wrap_song", 32'(dut.song), 32'd0);

      // Held next button counts once.
      tick();
      next_button = 1'b1;
      repeat (5) tick();
      next_button = 1'b0;
      tick();
      check("held_song", 32'(dut.song), 32'd1);

      // Asynchronous reset mid-song.
      pulse(1'b1, 1'b0);
      repeat (5) tick();
      check("pre_rst_sample", 32'(sample_out), POS);
      #2;
      reset = 1'b0;
      #1;
      check("arst_sample", 32'(sample_out), 32'h0);
      check("arst_state",  32'(dut.state), 32'd0);
      check("arst_song",   32'(dut.song), 32'd0);
      check("arst_index",  32'(dut.index), 32'd0);
      check("arst_beat",   32'(dut.beat_cnt), 32'd0);
      tick();
      reset = 1'b1;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/music_player.md
MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 Parameter BEAT_COUNT, default 500: clk cycles per beat (benches use 10).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 play_button  input  1  debounced play/pause request, synchronous to clk.
REQ-005 next_button  input  1  debounced next-song request, synchronous to clk.
REQ-006 new_frame  input  1  one-cycle codec sample-accept strobe (~48 kHz).
REQ-007 sample_out  output  16  signed two's-complement PCM sample, fed to both codec channels.

Function
REQ-008 Buttons SHALL be rising-edge detected internally; a held button counts once.
REQ-009 FSM states PAUSED and PLAYING; PLAYING/PAUSED toggle on play edge, effective the next cycle.
REQ-010 Next edge: song <= (song+1) mod 4, note index <= 0, state <= PAUSED, beat counter cleared.
REQ-011 Play and next edges in the same cycle: next wins; play ignored.
REQ-012 Beat counter SHALL run only in PLAYING, counting 0..BEAT_COUNT-1, emitting a one-cycle beat pulse on wrap; frozen (value held) in PAUSED.
REQ-013 Song ROM: 4 songs x 32 entries, 12-bit entry {note[5:0], duration[5:0]}, address {song[1:0], index[4:0]}; combinational read.
REQ-014 note 0 = rest; note 1..63 = index into 64-entry phase-step table (20-bit steps).
REQ-015 On each note load, remaining <= duration; each beat pulse in PLAYING decrements remaining; at 1 -> 0 transition index increments and next entry loads same cycle.
REQ-016 Entry with duration 0 = end marker: state <= PAUSED, index <= 0, song unchanged.
REQ-017 Index 31 completing SHALL wrap to 0 and continue playing.
REQ-018 Tone: 20-bit phase accumulator advances by step only on new_frame while PLAYING and note != 0; reset to 0 on every note load.
REQ-019 sample_out SHALL update only on the cycle after new_frame: +16'sh1000 if phase[19]=0, -16'sh1000 (16'hF000) if phase[19]=1; 16'h0000 when PAUSED or rest.
REQ-020 Pause mid-note preserves index, remaining, beat count and phase; resume continues exactly.

Reset
REQ-021 Asserted reset: state PAUSED, song 0, index 0, remaining loaded on first cycle after release, beat counter 0, phase 0, edge-detect registers 0, sample_out 16'h0000.
REQ-022 Reset mid-song aborts immediately to the REQ-021 values; no output glitch beyond 0.

Structure
REQ-023 Shared package music_pkg: NUM_SONGS=4, NOTES_PER_SONG=32, widths, song ROM contents, phase-step table, AMPLITUDE=16'sh1000.
REQ-024 One sub-module note_player (phase accumulator + sample register); FSM, beat counter and sequencing in music_player.
REQ-025 Song 0 entry 0 SHALL be a non-rest note with duration >= 2; each song SHALL contain an end marker.

Verification
REQ-026 Reset, 25 idle cycles, frames running -> sample_out stays 0, state PAUSED, song 0.
REQ-027 BEAT_COUNT=10, play pulse -> PLAYING next cycle; sample_out toggles +/-0x1000 at song-0 note-1 rate; index advances after duration x 10 cycles.
REQ-028 Pause after 2,000,000 cycles -> sample_out 0 after next frame; index/remaining frozen for 500,000 cycles; play resumes same note, same phase.
REQ-029 Next pulse while PLAYING -> song 1, index 0, PAUSED, sample 0; later play starts song-1 entry 0.
REQ-030 Play and next asserted same cycle -> song increments, state PAUSED.
REQ-031 Play through an end marker -> PAUSED, index 0, song unchanged; next after song 3 wraps to song 0.
